// File: rtl/sha256_msg_schedule_if.sv
// SHA-256 message schedule interface: block capture on the host side and the
// W_t word stream towards the compression rounds.
// Optional wk_out (W_t + K_t) is present when SHA256_SCHED_WK_EN is defined.
interface sha256_msg_schedule_if #(
  parameter int unsigned IDX_W = 6
);
  logic             start;
  logic [511:0]     block_in;
  logic             busy;
  logic             w_valid;
  logic             w_ready;
  logic [31:0]      w_out;
  logic [IDX_W-1:0] w_idx;
  logic             done;
`ifdef SHA256_SCHED_WK_EN
  logic [31:0]      wk_out;

  // Host / round-logic side.
  modport master (
    output start, block_in, w_ready,
    input  busy, w_valid, w_out, w_idx, done, wk_out
  );

  // Schedule expander side.
  modport slave (
    input  start, block_in, w_ready,
    output busy, w_valid, w_out, w_idx, done, wk_out
  );
`else
  // Host / round-logic side.
  modport master (
    output start, block_in, w_ready,
    input  busy, w_valid, w_out, w_idx, done
  );

  // Schedule expander side.
  modport slave (
    input  start, block_in, w_ready,
    output busy, w_valid, w_out, w_idx, done
  );
`endif
endinterface

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule expander.
// Captures a 512-bit block on start and streams W_0..W_{ROUNDS-1}, one word per
// accepted beat, using a 16-entry circular buffer (W_t overwrites W_{t-16}).
// Optional feature macro: SHA256_SCHED_WK_EN adds wk_out = W_t + K_t.
module sha256_msg_schedule #(
  parameter int unsigned ROUNDS = 64,
  parameter int unsigned IDX_W  = 6
) (
  input logic                  clk,
  input logic                  rstn,
  sha256_msg_schedule_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StStream, StDone} state_e;

  state_e           state;
  logic [31:0]      wbuf [16];
  logic [IDX_W-1:0] nt;
  logic [3:0]       slot;
  logic [31:0]      w_new;
  logic [31:0]      w_next;
  logic             beat;
  logic             last;

`ifdef SHA256_SCHED_WK_EN
  localparam logic [31:0] KTab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
`endif

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Next word: the loaded block word for t < 16, otherwise the expansion of
  // the four live buffer slots. slot holds W_{t-16}, about to be replaced.
  always_comb begin
    nt     = bus.w_idx + IDX_W'(1);
    slot   = nt[3:0];
    w_new  = sig1(wbuf[4'(slot - 4'd2)]) + wbuf[4'(slot - 4'd7)]
           + sig0(wbuf[4'(slot - 4'd15)]) + wbuf[slot];
    w_next = (int'(nt) < 16) ? wbuf[slot] : w_new;
    beat   = bus.w_valid & bus.w_ready;
    last   = (bus.w_idx == IDX_W'(ROUNDS - 1));
  end

  // Control FSM with registered stream outputs and buffer updates.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= StIdle;
      bus.busy    <= 1'b0;
      bus.w_valid <= 1'b0;
      bus.w_out   <= '0;
      bus.w_idx   <= '0;
      bus.done    <= 1'b0;
`ifdef SHA256_SCHED_WK_EN
      bus.wk_out  <= '0;
`endif
      for (int i = 0; i < 16; i++) wbuf[i] <= '0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (bus.start) begin
            for (int i = 0; i < 16; i++) wbuf[i] <= bus.block_in[511 - 32*i -: 32];
            bus.w_idx <= '0;
            bus.busy  <= 1'b1;
            state     <= StLoad;
          end
        end
        StLoad: begin
          bus.w_valid <= 1'b1;
          bus.w_out   <= wbuf[0];
          bus.w_idx   <= '0;
`ifdef SHA256_SCHED_WK_EN
          bus.wk_out  <= wbuf[0] + KTab[0];
`endif
          state       <= StStream;
        end
        StStream: begin
          if (beat) begin
            if (last) begin
              bus.w_valid <= 1'b0;
              bus.busy    <= 1'b0;
              bus.done    <= 1'b1;
              state       <= StDone;
            end else begin
              // For t < 16 this rewrites the slot with its own value.
              wbuf[slot] <= w_next;
              bus.w_out  <= w_next;
              bus.w_idx  <= nt;
`ifdef SHA256_SCHED_WK_EN
              bus.wk_out <= w_next + KTab[6'(nt)];
`endif
            end
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed testbench for sha256_msg_schedule.
module tb_sha256_msg_schedule;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  sha256_msg_schedule_if #(.IDX_W(6)) bus ();

  sha256_msg_schedule #(.ROUNDS(64), .IDX_W(6)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0]  exp_w [64];
  logic [31:0]  got_w [64];
  logic [31:0]  got_wk0;
  int           last_cyc;
  logic [511:0] abc_blk;
  logic [511:0] ones_blk;
  logic [511:0] pat_blk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Straight FIPS-style reference: full 64-word array.
  task automatic compute_model(input logic [511:0] b);
    for (int i = 0; i < 16; i++) exp_w[i] = b[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      exp_w[i] = (rotr(exp_w[i-2], 17) ^ rotr(exp_w[i-2], 19) ^ (exp_w[i-2] >> 10))
               + exp_w[i-7]
               + (rotr(exp_w[i-15], 7) ^ rotr(exp_w[i-15], 18) ^ (exp_w[i-15] >> 3))
               + exp_w[i-16];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a block and consume the whole stream, checking every word against
  // exp_w; optionally randomise w_ready and pulse start while streaming.
  task automatic run_stream(input logic [511:0] blk, input bit rnd, input int inj_t,
                            input logic [511:0] inj_blk);
    int          n;
    int          cyc;
    bit          fin;
    bit          pv;
    bit          pr;
    logic [31:0] pw;
    logic [5:0]  pi;
    bus.block_in = blk;
    bus.start    = 1'b1;
    step();
    bus.start    = 1'b0;
    bus.block_in = ~blk;
    checks++;
    if (bus.busy !== 1'b1 || bus.w_valid !== 1'b0) begin
      errors++;
      $display("FAIL load_state: busy=%b w_valid=%b, want busy=1 w_valid=0",
               bus.busy, bus.w_valid);
    end
    step();
    checks++;
    if (bus.w_valid !== 1'b1 || bus.w_idx !== 6'd0) begin
      errors++;
      $display("FAIL first_word_latency: w_valid=%b w_idx=%0d, want 1 and 0",
               bus.w_valid, bus.w_idx);
    end
    n = 0; cyc = 0; fin = 0; pv = 0; pr = 0; pw = '0; pi = '0;
    while (!fin && cyc < 1000) begin
      if (pv && !pr) begin
        checks++;
        if (bus.w_valid !== 1'b1 || bus.w_out !== pw || bus.w_idx !== pi) begin
          errors++;
          $display("FAIL hold: valid=%b w_out=%h w_idx=%0d, want 1 %h %0d",
                   bus.w_valid, bus.w_out, bus.w_idx, pw, pi);
        end
      end
      bus.w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inj_t >= 0 && bus.w_valid === 1'b1 && int'(bus.w_idx) == inj_t) begin
        bus.start    = 1'b1;
        bus.block_in = inj_blk;
      end else begin
        bus.start = 1'b0;
      end
      pv = (bus.w_valid === 1'b1);
      pr = bus.w_ready;
      pw = bus.w_out;
      pi = bus.w_idx;
      if (bus.w_valid === 1'b1 && bus.w_ready === 1'b1) begin
        checks++;
        got_w[n] = bus.w_out;
`ifdef SHA256_SCHED_WK_EN
        if (n == 0) got_wk0 = bus.wk_out;
`endif
        if (bus.w_idx !== 6'(n) || bus.w_out !== exp_w[n]) begin
          errors++;
          $display("FAIL word: w_idx=%0d w_out=%h, want idx=%0d w=%h",
                   bus.w_idx, bus.w_out, n, exp_w[n]);
        end
        if (n == 63) fin = 1;
        n++;
      end
      step();
      cyc++;
    end
    bus.start = 1'b0;
    last_cyc  = cyc;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL stream_timeout: got %0d words, want 64", n);
    end else if (bus.w_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse: valid=%b busy=%b done=%b, want 0 0 1",
               bus.w_valid, bus.busy, bus.done);
    end
  endtask

  // Leave the DONE cycle and confirm done dropped.
  task automatic finish_stream();
    step();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL done_width: done=%b busy=%b, want 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (bus.busy !== 1'b0 || bus.w_valid !== 1'b0 || bus.w_out !== 32'h0 ||
        bus.w_idx !== 6'd0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy=%b valid=%b w_out=%h idx=%0d done=%b, want all 0",
               tag, bus.busy, bus.w_valid, bus.w_out, bus.w_idx, bus.done);
    end
`ifdef SHA256_SCHED_WK_EN
    checks++;
    if (bus.wk_out !== 32'h0) begin
      errors++;
      $display("FAIL %s_wk: wk_out=%h, want 0", tag, bus.wk_out);
    end
`endif
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.start = 1'b0;
    bus.w_ready = 1'b0;
    bus.block_in = '0;
    step();
    step();
    check_reset_outputs("reset_state");
    rstn = 1'b1;
    step();
    check_reset_outputs("idle_after_release");
  endtask

  task automatic test_abc();
    compute_model(abc_blk);
    run_stream(abc_blk, 1'b0, -1, '0);
    checks++;
    if (got_w[0] !== 32'h61626380 || got_w[15] !== 32'h00000018 ||
        got_w[16] !== 32'h61626380 || got_w[17] !== 32'h000f0000 ||
        got_w[63] !== 32'h12b1edeb) begin
      errors++;
      $display("FAIL abc_known: W0=%h W15=%h W16=%h W17=%h W63=%h, want %s",
               got_w[0], got_w[15], got_w[16], got_w[17], got_w[63],
               "61626380 00000018 61626380 000f0000 12b1edeb");
    end
    checks++;
    if (last_cyc != 64) begin
      errors++;
      $display("FAIL done_latency: %0d cycles from W_0 to done, want 64", last_cyc);
    end
    finish_stream();
  endtask

  task automatic test_backpressure();
    compute_model(abc_blk);
    run_stream(abc_blk, 1'b1, -1, '0);
    finish_stream();
  endtask

  task automatic test_all_ones();
    compute_model(ones_blk);
    run_stream(ones_blk, 1'b0, -1, '0);
    checks++;
    if (got_w[16] !== 32'h203ffffc) begin
      errors++;
      $display("FAIL ones_w16: W16=%h, want 203ffffc", got_w[16]);
    end
    finish_stream();
  endtask

  task automatic test_start_ignored();
    compute_model(abc_blk);
    run_stream(abc_blk, 1'b0, 20, ones_blk);
    // start during the done cycle must not capture
    bus.start    = 1'b1;
    bus.block_in = ones_blk;
    step();
    bus.start = 1'b0;
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.w_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done: busy=%b valid=%b, want 0 0", bus.busy, bus.w_valid);
    end
    compute_model(ones_blk);
    run_stream(ones_blk, 1'b0, -1, '0);
    finish_stream();
  endtask

  task automatic test_reset_midstream();
    int cyc;
    bus.block_in = abc_blk;
    bus.start    = 1'b1;
    step();
    bus.start   = 1'b0;
    bus.w_ready = 1'b1;
    cyc = 0;
    while (!(bus.w_valid === 1'b1 && bus.w_idx === 6'd30) && cyc < 200) begin
      step();
      cyc++;
    end
    checks++;
    if (cyc >= 200) begin
      errors++;
      $display("FAIL reach_t30: w_idx=%0d, want 30", bus.w_idx);
    end
    rstn = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    step();
    rstn = 1'b1;
    step();
    check_reset_outputs("no_resume");
    compute_model(pat_blk);
    run_stream(pat_blk, 1'b0, -1, '0);
    finish_stream();
  endtask

`ifdef SHA256_SCHED_WK_EN
  task automatic test_wk();
    compute_model(abc_blk);
    run_stream(abc_blk, 1'b0, -1, '0);
    finish_stream();
    checks++;
    if (got_wk0 !== 32'ha3ec9318) begin
      errors++;
      $display("FAIL wk0: wk_out=%h, want a3ec9318", got_wk0);
    end
  endtask
`endif

  initial begin
    abc_blk  = {32'h61626380, 448'h0, 32'h00000018};
    ones_blk = {512{1'b1}};
    pat_blk  = {8{64'h0123456789abcdef}};
    got_wk0  = '0;
    test_reset();
    test_abc();
    test_backpressure();
    test_all_ones();
    test_start_ignored();
    test_reset_midstream();
`ifdef SHA256_SCHED_WK_EN
    test_wk();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
